// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CHK_W      = 8;

  // States in which a stream byte may be taken on the next edge.
  function automatic logic accepts_byte(input state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs four stream bytes, least-significant first, into one 32-bit word.
// Used by imem_loader in every build (IMEM_LOADER_CHECKSUM_EN does not affect it).
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] idx;

  // New bytes enter at the top so the first byte ends up in lane 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (load) begin
      idx  <= idx + 2'd1;
      word <= {byte_in, word[31:8]};
    end
  end

  assign word_full = load && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory writes, pipeline held until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state   | meaning
// HDR_LO  | waiting for word-count low byte
// HDR_HI  | waiting for word-count high byte, range check
// DATA    | collecting the 4 bytes of the current word
// WRITE   | one-cycle memory write strobe, address advance
// CHK     | waiting for checksum byte (checksum builds only)
// DONE    | program loaded, pipeline released
// ERROR   | load aborted, pipeline stays frozen
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_data_in,
  output logic              imem_wr,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned MAX_WORDS = (32'd1 << ADDR_W) / ADDR_STEP;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = ST_CHK;
`else
  localparam state_t END_STATE = ST_DONE;
`endif

  state_t            state, state_next;
  logic              byte_ready_q;
  logic [7:0]        cnt_lo;
  logic [15:0]       remaining;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [15:0]       count_full;
  logic              asm_load, asm_clear, word_full;
  logic [31:0]       word;

  assign accept     = byte_valid && byte_ready_q;
  assign count_full = {byte_data, cnt_lo};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHK_W-1:0] chk_acc;

  // Running XOR over header and data bytes; the checksum byte itself is excluded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chk_acc <= '0;
    end else if (accept && (state == ST_HDR_LO || state == ST_HDR_HI || state == ST_DATA)) begin
      chk_acc <= chk_acc ^ byte_data;
    end
  end
`endif

  byte_word_assembler u_asm (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (asm_load),
    .clear     (asm_clear),
    .byte_in   (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    asm_load   = 1'b0;
    asm_clear  = (state == ST_HDR_LO);
    case (state)
      ST_HDR_LO: if (accept) state_next = ST_HDR_HI;
      ST_HDR_HI: begin
        if (accept) begin
          if (count_full == 16'd0)                    state_next = END_STATE;
          else if (32'(count_full) > MAX_WORDS)       state_next = ST_ERROR;
          else                                        state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        asm_load = accept;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: state_next = (remaining == 16'd1) ? END_STATE : ST_DATA;
      ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_next = (byte_data == chk_acc) ? ST_DONE : ST_ERROR;
`else
        state_next = ST_ERROR;
`endif
      end
      ST_DONE:  state_next = ST_DONE;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_HDR_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_HDR_LO;
      byte_ready_q <= 1'b1;
      cnt_lo       <= 8'd0;
      remaining    <= 16'd0;
      addr         <= ADDR_W'(BASE_ADDR);
    end else begin
      state        <= state_next;
      byte_ready_q <= accepts_byte(state_next);
      if (state == ST_HDR_LO && accept) cnt_lo <= byte_data;
      if (state == ST_HDR_HI && accept) remaining <= count_full;
      if (state == ST_WRITE) begin
        addr      <= addr + ADDR_W'(ADDR_STEP);
        remaining <= remaining - 16'd1;
      end
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_addr    = addr;
  assign imem_data_in = DATA_W'(word);
  assign imem_wr      = (state == ST_WRITE);
  assign core_hold    = (state != ST_DONE);
  assign load_done    = (state == ST_DONE);
  assign load_error   = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN when the same define is given to the bench.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic [11:0] imem_addr;
  logic [31:0] imem_data_in;
  logic        imem_wr, core_hold, load_done, load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [11:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_error;
  logic [11:0] last_addr;
  logic [31:0] last_data;

  always #5 clock = ~clock;

  imem_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_addr    (imem_addr),
    .imem_data_in (imem_data_in),
    .imem_wr      (imem_wr),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what a stream (of which 'delivered' bytes arrive) must produce.
  task automatic model(input bq_t s, input int delivered);
    int n;
    logic [7:0] x;
    exp_done  = 1'b0;
    exp_error = 1'b0;
    if (delivered < 2) return;
    n = int'({s[1], s[0]});
    x = s[0] ^ s[1];
    if (n > 4096 / 4) begin
      exp_error = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (2 + 4 * w + 4 > delivered) return;
      exp_addr.push_back(12'((4 * w) % 4096));
      exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
      x = x ^ s[2+4*w] ^ s[2+4*w+1] ^ s[2+4*w+2] ^ s[2+4*w+3];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (delivered < 2 + 4 * n + 1) return;
    if (s[2+4*n] == x) exp_done = 1'b1;
    else exp_error = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  function automatic logic [7:0] xor_all(input bq_t s);
    logic [7:0] x = 8'd0;
    foreach (s[i]) x = x ^ s[i];
    return x;
  endfunction

  task automatic make_stream(input wq_t words, output bq_t s);
    int n;
    logic [31:0] w;
    s = {};
    n = words.size();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(xor_all(s));
`endif
  endtask

  // Called at a falling edge; byte_ready seen there is what the next rising edge uses.
  task automatic push(input bq_t s, input int budget, output int taken, output int lows,
                      output int cycles);
    logic acc;
    taken = 0;
    lows = 0;
    cycles = 0;
    while (taken < s.size() && cycles < budget) begin
      byte_valid = 1'b1;
      byte_data  = s[taken];
      acc = byte_ready;
      if (!acc) lows++;
      @(negedge clock);
      cycles++;
      if (acc) taken++;
    end
    byte_valid = 1'b0;
    byte_data  = 8'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    n_writes = 0;
    @(negedge clock);
  endtask

  task automatic finish_load(input string tag);
    check({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_error"}, 32'(load_error), 32'(exp_error));
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_wr) begin
        n_writes++;
        last_addr = imem_addr;
        last_data = imem_data_in;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   imem_addr, imem_data_in);
        end else begin
          check("wr_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
          check("wr_data", imem_data_in, exp_data.pop_front());
        end
        check("wr_ready_low", 32'(byte_ready), 32'd0);
      end
      check("hold_vs_done", 32'(core_hold), 32'(!load_done));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s, part;
    wq_t words;
    int taken, lows, cycles;

    // Reset values while reset is asserted.
    @(negedge clock);
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_wr", 32'(imem_wr), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_data", imem_data_in, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    do_reset();

    // Two-word program from the test plan.
    s = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(xor_all(s));
`endif
    model(s, s.size());
    check("model_w0_data", exp_data[0], 32'h00000013);
    check("model_w1_addr", 32'(exp_addr[1]), 32'h004);
    check("model_w1_data", exp_data[1], 32'h005000B3);
    push(s, 60, taken, lows, cycles);
    check("t1_taken", 32'(taken), 32'(s.size()));
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_wr_after_last_byte", 32'(imem_wr), 32'd1);
    check("t1_hold_during_write", 32'(core_hold), 32'd1);
    @(negedge clock);
`endif
    check("t1_load_done", 32'(load_done), 32'd1);
    check("t1_core_hold", 32'(core_hold), 32'd0);
    check("t1_last_addr", 32'(last_addr), 32'h004);
    check("t1_last_data", last_data, 32'h005000B3);
    check("t1_n_writes", 32'(n_writes), 32'd2);
    finish_load("t1");
    do_reset();

    // Empty program.
    words = {};
    make_stream(words, s);
    model(s, s.size());
    push(s, 20, taken, lows, cycles);
    check("t2_taken", 32'(taken), 32'(s.size()));
    check("t2_done_next_edge", 32'(load_done), 32'd1);
    check("t2_n_writes", 32'(n_writes), 32'd0);
    finish_load("t2");
    do_reset();

    // Oversize count 0x0401.
    s = {8'h01, 8'h04};
    model(s, s.size());
    push(s, 20, taken, lows, cycles);
    check("t3_taken", 32'(taken), 32'd2);
    check("t3_error", 32'(load_error), 32'd1);
    check("t3_hold", 32'(core_hold), 32'd1);
    check("t3_ready", 32'(byte_ready), 32'd0);
    s = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push(s, 8, taken, lows, cycles);
    check("t3_no_consume", 32'(taken), 32'd0);
    check("t3_n_writes", 32'(n_writes), 32'd0);
    finish_load("t3");
    do_reset();

    // Continuous three-word stream: one dead cycle per written word.
    words = {32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};
    make_stream(words, s);
    model(s, s.size());
    push(s, 60, taken, lows, cycles);
    check("t4_taken", 32'(taken), 32'(s.size()));
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t4_ready_lows", 32'(lows), 32'd3);
`else
    check("t4_ready_lows", 32'(lows), 32'd2);
    check("t4_ready_low_in_last_write", 32'(byte_ready), 32'd0);
    @(negedge clock);
`endif
    check("t4_cycles", 32'(cycles), 32'(s.size() + lows));
    check("t4_last_data", last_data, 32'hDEADBEEF);
    check("t4_last_addr", 32'(last_addr), 32'h008);
    finish_load("t4");
    do_reset();

    // Reset after 2 bytes of the third word.
    make_stream(words, s);
    part = {};
    for (int i = 0; i < 12; i++) part.push_back(s[i]);
    model(s, 12);
    push(part, 40, taken, lows, cycles);
    check("t5_taken", 32'(taken), 32'd12);
    check("t5_pending_writes", 32'(exp_addr.size()), 32'd0);
    check("t5_n_writes", 32'(n_writes), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(byte_ready), 32'd1);
    check("t5_rst_hold", 32'(core_hold), 32'd1);
    check("t5_rst_addr", 32'(imem_addr), 32'd0);
    check("t5_rst_data", imem_data_in, 32'd0);
    check("t5_rst_wr", 32'(imem_wr), 32'd0);
    check("t5_rst_flags", 32'({load_done, load_error}), 32'd0);
    do_reset();
    words = {32'hCAFEF00D};
    make_stream(words, s);
    model(s, s.size());
    push(s, 30, taken, lows, cycles);
    repeat (2) @(negedge clock);
    check("t5_fresh_addr", 32'(last_addr), 32'h000);
    check("t5_fresh_data", last_data, 32'hCAFEF00D);
    check("t5_fresh_n_writes", 32'(n_writes), 32'd1);
    finish_load("t5");
    do_reset();

    // Largest legal program (1024 words) fills the space and wraps the address.
    words = {};
    for (int i = 0; i < 1024; i++) words.push_back({i[15:0], ~i[15:0]});
    make_stream(words, s);
    model(s, s.size());
    push(s, 6000, taken, lows, cycles);
    check("t6_taken", 32'(taken), 32'(s.size()));
    repeat (2) @(negedge clock);
    check("t6_n_writes", 32'(n_writes), 32'd1024);
    check("t6_last_addr", 32'(last_addr), 32'hFFC);
    check("t6_addr_wrapped", 32'(imem_addr), 32'h000);
    finish_load("t6");
    do_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accept and reject.
    s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    check("t7_model_xor", 32'(xor_all(s)), 32'h12);
    s.push_back(8'h12);
    model(s, s.size());
    push(s, 30, taken, lows, cycles);
    check("t7_good_done", 32'(load_done), 32'd1);
    check("t7_good_hold", 32'(core_hold), 32'd0);
    finish_load("t7_good");
    do_reset();
    s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    model(s, s.size());
    push(s, 30, taken, lows, cycles);
    check("t7_bad_error", 32'(load_error), 32'd1);
    check("t7_bad_hold", 32'(core_hold), 32'd1);
    check("t7_bad_ready", 32'(byte_ready), 32'd0);
    finish_load("t7_bad");
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It drives the instruction memory write port (`addr`/`data_in`/`wr`) while holding the pipeline frozen, and releases the pipeline once the whole program is written. It sits beside the fetch stage and owns the instruction-memory write side, which the pipeline itself never drives.

## Interface
Parameters:
- `ADDR_W`, 12: instruction memory address width.
- `DATA_W`, 32: instruction word width. Fixed at 4 bytes.
- `ADDR_STEP`, 4: address increment per written word.
- `BASE_ADDR`, 0: address of the first written word.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `byte_valid`, input, 1: `byte_data` is valid.
- `byte_data`, input, 8: stream byte.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `imem_addr`, output, ADDR_W: instruction memory write address.
- `imem_data_in`, output, DATA_W: instruction memory write data.
- `imem_wr`, output, 1: instruction memory write strobe, one cycle per word.
- `core_hold`, output, 1: freezes the PC and pipeline registers while high.
- `load_done`, output, 1: sticky; the program is fully written.
- `load_error`, output, 1: sticky; the load was aborted.

## Operation
- A byte is accepted on a rising edge where `byte_valid && byte_ready`.
- Stream format:
  - Word count N: 16-bit, low byte first.
  - Then N words, 4 bytes each, least-significant byte first.
  - With checksum enabled, one trailing checksum byte follows.
- States:
  - HDR_LO: take the count low byte; go to HDR_HI.
  - HDR_HI: take the count high byte.
    - N == 0: go to DONE, or CHK if enabled.
    - N > 2^ADDR_W / ADDR_STEP: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: shift bytes into the word register, low byte first. On the 4th byte go to WRITE.
  - WRITE: `imem_wr`=1 for exactly one cycle; `byte_ready`=0. At the end of the cycle:
    - `imem_addr` += ADDR_STEP, wrapping modulo 2^ADDR_W.
    - The remaining-word count decrements.
    - Count reaches 0: go to DONE, or CHK if enabled. Otherwise go back to DATA.
  - CHK: compare the received byte with the running XOR; go to DONE on match, ERROR on mismatch.
  - DONE: `core_hold`=0, `load_done`=1, `byte_ready`=0. Terminal until reset.
  - ERROR: `core_hold`=1, `load_error`=1, `byte_ready`=0. Terminal until reset.
- `imem_addr` and `imem_data_in` stay stable for the whole WRITE cycle.
- Bytes offered while `byte_ready`=0 are not consumed. The source must hold them.

## Timing
- Reset values:
  - State: HDR_LO.
  - `byte_ready`=1, `core_hold`=1.
  - `imem_wr`=0, `imem_addr`=BASE_ADDR, `imem_data_in`=0.
  - `load_done`=0, `load_error`=0.
- Latency: the 4th byte of a word is accepted at edge k. `imem_wr` is high from edge k to edge k+1, and the memory captures the word at edge k+1.
- Maximum throughput: 4 bytes per 5 cycles.
- `core_hold` falls and `load_done` rises on the edge that enters DONE: the edge closing the last WRITE cycle, or the checksum-accept edge.
- Reset mid-load: all outputs return to reset values asynchronously. A write strobe in progress is dropped. Already-written words stay in memory.
- `byte_ready` is registered. It never depends combinationally on `byte_valid`.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
  - Defined: CHK state present. A running XOR covers the two header bytes and all data bytes. One extra byte is expected after the last word.
  - Undefined: no CHK state and no trailing byte. `load_error` can only come from an oversize N.

## Structure
- Package `imem_loader_pkg`:
  - State encoding constants.
  - `HDR_BYTES`=2 and `WORD_BYTES`=4.
  - Checksum byte width.
- Sub-module `byte_word_assembler`:
  - 2-bit byte index plus a 32-bit shift register.
  - Inputs: load-enable and clear. Output: `word_full` on the 4th byte.

## Test plan
- Count 0x0002, bytes 13 00 00 00 B3 00 50 00:
  - `imem_wr` pulses twice: addr 0x000/data 0x00000013, then addr 0x004/data 0x005000B3.
  - Then `load_done`=1 and `core_hold`=0.
- Count 0x0000: no `imem_wr`; DONE is entered one edge after HDR_HI (checksum off).
- Count 0x0401: `load_error`=1, `core_hold`=1, `byte_ready`=0; no `imem_wr`, and further bytes are not consumed.
- `byte_valid` held high with a continuous stream of 3 words:
  - `byte_ready` is low exactly one cycle per word.
  - All 12 data bytes land in the correct word and byte lanes.
- `reset_n` pulsed low after 2 bytes of word 3:
  - Outputs return to reset values immediately.
  - A fresh 1-word load then writes addr 0x000.
- With `IMEM_LOADER_CHECKSUM_EN`, count 1 and word 0x00000013: checksum byte 0x12 gives DONE; checksum byte 0x13 gives ERROR with `core_hold`=1.
